// File: rtl/plc_pkg.sv
// -----------------------------------------------------------------------------
// plc_pkg
// Shared definitions for the multi-mode pump controller:
//   - controller state encoding (localparams plus the enum built on them)
//   - level-zone encoding for the one-hot {H, M, L} zone register
//   - small helpers that classify states
// No ports; imported by multi_mode_pump_plc and plc_watchdog.
// -----------------------------------------------------------------------------
package plc_pkg;

  // Controller state encoding.
  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_FILL          = 3'd0;
  localparam logic [STATE_W-1:0] ST_DRAIN         = 3'd1;
  localparam logic [STATE_W-1:0] ST_DEAD_TO_DRAIN = 3'd2;
  localparam logic [STATE_W-1:0] ST_DEAD_TO_FILL  = 3'd3;
  localparam logic [STATE_W-1:0] ST_FAULT         = 3'd4;

  typedef enum logic [STATE_W-1:0] {
    FILL          = ST_FILL,
    DRAIN         = ST_DRAIN,
    DEAD_TO_DRAIN = ST_DEAD_TO_DRAIN,
    DEAD_TO_FILL  = ST_DEAD_TO_FILL,
    FAULT         = ST_FAULT
  } plc_state_e;

  // Level-zone encoding, bit order {H, M, L}.
  localparam int ZONE_W = 3;

  localparam logic [ZONE_W-1:0] ZONE_L = 3'b001;
  localparam logic [ZONE_W-1:0] ZONE_M = 3'b010;
  localparam logic [ZONE_W-1:0] ZONE_H = 3'b100;

  // Both-pumps-off dwell states.
  function automatic logic is_dead(input plc_state_e s);
    return (s == DEAD_TO_DRAIN) || (s == DEAD_TO_FILL);
  endfunction

  // States in which a pump runs and run_cnt advances.
  function automatic logic is_running(input plc_state_e s);
    return (s == FILL) || (s == DRAIN);
  endfunction

endpackage

// File: rtl/plc_watchdog.sv
// -----------------------------------------------------------------------------
// plc_watchdog
// Counts cycles since the last kick. Reports expiry once WDOG_CYC cycles have
// passed without a kick. A kick in the expiry cycle wins, so expired is never
// raised in a cycle that carries a kick.
//
// Ports
//   CLK100MHZ  in   clock, rising edge
//   rst        in   synchronous active-high reset (counter cleared)
//   kick       in   restart the interval (a valid level sample)
//   expired    out  combinational: interval elapsed and no kick this cycle
// -----------------------------------------------------------------------------
module plc_watchdog
  import plc_pkg::*;
#(
  parameter int WDOG_CYC = 1024
) (
  input  logic CLK100MHZ,
  input  logic rst,
  input  logic kick,
  output logic expired
);

  localparam int CNT_W = (WDOG_CYC > 1) ? $clog2(WDOG_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WDOG_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // After the last kick the counter climbs to WDOG_CYC-1 and parks there;
  // the next kick-free edge is the WDOG_CYC-th and trips the fault.
  always_comb begin
    cnt_d = cnt_q;
    if (kick) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_LAST) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = !kick && (cnt_q == CNT_LAST);

endmodule

// File: rtl/multi_mode_pump_plc.sv
// -----------------------------------------------------------------------------
// multi_mode_pump_plc
// Tank level controller driving a fill pump and a drain pump with hysteresis,
// a minimum drain run time, a both-off dead time on every direction change,
// sample plausibility checking and a sample watchdog.
//
// Handshake: water_lvl is taken only in a cycle with lvl_valid=1; there is no
// back-pressure. A valid sample above LVL_MAX is not stored and forces FAULT.
// All control decisions use the stored sample lvl_q, so a sample accepted at
// edge k first influences state and pump outputs at edge k+1.
//
// Legal parameters: LOW_TH < MID_TH < HIGH_TH <= LVL_MAX < 2**LVL_W,
// DEAD_CYC >= 1.
//
// Ports
//   CLK100MHZ            in   clock, rising edge
//   rst                  in   synchronous active-high reset
//   water_lvl[LVL_W]     in   level sample
//   lvl_valid            in   water_lvl valid this cycle
//   fault_clr            in   fault acknowledge (only honoured in FAULT)
//   pump1_ctrl           out  fill pump
//   pump2_ctrl           out  drain pump
//   L / M / H            out  one-hot level zone of lvl_q
//   water_trend          out  1 = filling, 0 = draining
//   fault                out  controller in FAULT
//   water_lvl_indicator  out  last accepted sample (lvl_q)
// -----------------------------------------------------------------------------
module multi_mode_pump_plc
  import plc_pkg::*;
#(
  parameter int LVL_W    = 8,
  parameter int LOW_TH   = 20,
  parameter int MID_TH   = 50,
  parameter int HIGH_TH  = 90,
  parameter int LVL_MAX  = 100,
  parameter int DEAD_CYC = 4,
  parameter int MIN_RUN  = 16,
  parameter int WDOG_CYC = 1024
) (
  input  logic             CLK100MHZ,
  input  logic             rst,
  input  logic [LVL_W-1:0] water_lvl,
  input  logic             lvl_valid,
  input  logic             fault_clr,
  output logic             pump1_ctrl,
  output logic             pump2_ctrl,
  output logic             L,
  output logic             M,
  output logic             H,
  output logic             water_trend,
  output logic             fault,
  output logic [LVL_W-1:0] water_lvl_indicator
);

  // Thresholds at sample width so every comparison is unsigned LVL_W bits.
  localparam logic [LVL_W-1:0] LOW_V  = LVL_W'(LOW_TH);
  localparam logic [LVL_W-1:0] MID_V  = LVL_W'(MID_TH);
  localparam logic [LVL_W-1:0] HIGH_V = LVL_W'(HIGH_TH);
  localparam logic [LVL_W-1:0] MAX_V  = LVL_W'(LVL_MAX);

  localparam int DEAD_W = $clog2(DEAD_CYC + 1);
  localparam int RUN_W  = (MIN_RUN > 0) ? $clog2(MIN_RUN + 1) : 1;

  localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEAD_CYC - 1);
  localparam logic [DEAD_W-1:0] DEAD_ONE  = DEAD_W'(1);
  localparam logic [RUN_W-1:0]  RUN_SAT   = RUN_W'(MIN_RUN);
  localparam logic [RUN_W-1:0]  RUN_ONE   = RUN_W'(1);

  plc_state_e        state_q, state_d;
  logic [DEAD_W-1:0] dead_cnt_q, dead_cnt_d;
  logic [RUN_W-1:0]  run_cnt_q, run_cnt_d;
  logic [LVL_W-1:0]  lvl_q, lvl_d;
  logic [ZONE_W-1:0] zone_q, zone_d;
  logic              pump1_q, pump1_d;
  logic              pump2_q, pump2_d;
  logic              fault_q, fault_d;
  logic              trend_q, trend_d;

  logic wdog_expired;
  logic sample_bad;
  logic fault_ev;
  logic dead_done;
  logic run_done;
  logic low_hit;

  plc_watchdog #(
    .WDOG_CYC (WDOG_CYC)
  ) u_wdog (
    .CLK100MHZ (CLK100MHZ),
    .rst       (rst),
    .kick      (lvl_valid),
    .expired   (wdog_expired)
  );

  assign sample_bad = lvl_valid && (water_lvl > MAX_V);
  assign fault_ev   = sample_bad || wdog_expired;
  assign dead_done  = (dead_cnt_q == DEAD_LAST);
  assign run_done   = (run_cnt_q >= RUN_SAT);
  // An empty tank must start refilling without waiting out MIN_RUN.
  assign low_hit    = (lvl_q <= LOW_V) && (run_done || (lvl_q == '0));

  // ---------------------------------------------------------------------------
  // Next-state logic. Fault entry overrides every other transition.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (fault_ev) begin
      state_d = FAULT;
    end else begin
      case (state_q)
        FILL: begin
          // Overflow safety: reverse immediately, no minimum run time.
          if (lvl_q >= HIGH_V) state_d = DEAD_TO_DRAIN;
        end
        DRAIN: begin
          if (low_hit) state_d = DEAD_TO_FILL;
        end
        DEAD_TO_DRAIN: begin
          if (dead_done) state_d = DRAIN;
        end
        DEAD_TO_FILL: begin
          if (dead_done) state_d = FILL;
        end
        FAULT: begin
          // fault_ev is already false here, so the watchdog is not expired.
          if (fault_clr) state_d = DEAD_TO_FILL;
        end
        default: state_d = FAULT;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Counters. Both restart from 0 on any state change, so entering a dead
  // state or a running state always begins a fresh count.
  // ---------------------------------------------------------------------------
  always_comb begin
    dead_cnt_d = '0;
    if ((state_d == state_q) && is_dead(state_q)) begin
      dead_cnt_d = dead_cnt_q + DEAD_ONE;
    end
  end

  always_comb begin
    run_cnt_d = '0;
    if ((state_d == state_q) && is_running(state_q)) begin
      run_cnt_d = run_done ? run_cnt_q : (run_cnt_q + RUN_ONE);
    end
  end

  // ---------------------------------------------------------------------------
  // Sample register and zone decode.
  // ---------------------------------------------------------------------------
  always_comb begin
    lvl_d = lvl_q;
    if (lvl_valid && !sample_bad) begin
      lvl_d = water_lvl;
    end
  end

  always_comb begin
    zone_d = ZONE_L;
    if (lvl_q >= HIGH_V) begin
      zone_d = ZONE_H;
    end else if (lvl_q >= MID_V) begin
      zone_d = ZONE_M;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs registered from the next state so they change at the same edge
  // as the state itself.
  // ---------------------------------------------------------------------------
  always_comb begin
    pump1_d = (state_d == FILL);
    pump2_d = (state_d == DRAIN);
    fault_d = (state_d == FAULT);
    trend_d = trend_q;
    case (state_d)
      FILL, DEAD_TO_FILL:   trend_d = 1'b1;
      DRAIN, DEAD_TO_DRAIN: trend_d = 1'b0;
      default:              trend_d = trend_q;
    endcase
  end

  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      state_q    <= DEAD_TO_FILL;
      dead_cnt_q <= '0;
      run_cnt_q  <= '0;
      lvl_q      <= '0;
      zone_q     <= ZONE_L;
      pump1_q    <= 1'b0;
      pump2_q    <= 1'b0;
      fault_q    <= 1'b0;
      trend_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      dead_cnt_q <= dead_cnt_d;
      run_cnt_q  <= run_cnt_d;
      lvl_q      <= lvl_d;
      zone_q     <= zone_d;
      pump1_q    <= pump1_d;
      pump2_q    <= pump2_d;
      fault_q    <= fault_d;
      trend_q    <= trend_d;
    end
  end

  assign pump1_ctrl          = pump1_q;
  assign pump2_ctrl          = pump2_q;
  assign L                   = zone_q[0];
  assign M                   = zone_q[1];
  assign H                   = zone_q[2];
  assign water_trend         = trend_q;
  assign fault               = fault_q;
  assign water_lvl_indicator = lvl_q;

endmodule

// File: tb/tb_multi_mode_pump_plc.sv
// -----------------------------------------------------------------------------
// tb_multi_mode_pump_plc
// Directed-vector bench for multi_mode_pump_plc with default parameters.
// Inputs are driven 1 ns after a rising edge and outputs are checked 1 ns
// after the following rising edge.
// -----------------------------------------------------------------------------
module tb_multi_mode_pump_plc;

  localparam int LVL_W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [LVL_W-1:0] water_lvl;
  logic             lvl_valid;
  logic             fault_clr;
  logic             pump1, pump2, l_o, m_o, h_o, trend, fault;
  logic [LVL_W-1:0] ind;

  int n_vec  = 0;
  int n_miss = 0;
  int prev;
  logic [2:0] zz;

  multi_mode_pump_plc #(
    .LVL_W    (8),
    .LOW_TH   (20),
    .MID_TH   (50),
    .HIGH_TH  (90),
    .LVL_MAX  (100),
    .DEAD_CYC (4),
    .MIN_RUN  (16),
    .WDOG_CYC (1024)
  ) dut (
    .CLK100MHZ           (clk),
    .rst                 (rst),
    .water_lvl           (water_lvl),
    .lvl_valid           (lvl_valid),
    .fault_clr           (fault_clr),
    .pump1_ctrl          (pump1),
    .pump2_ctrl          (pump2),
    .L                   (l_o),
    .M                   (m_o),
    .H                   (h_o),
    .water_trend         (trend),
    .fault               (fault),
    .water_lvl_indicator (ind)
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Output vector {pump1, pump2, L, M, H, trend, fault}.
  task automatic chk_out(input string tag, input logic p1, input logic p2,
                         input logic l, input logic m, input logic h,
                         input logic tr, input logic f);
    check(tag, {25'd0, pump1, pump2, l_o, m_o, h_o, trend, fault},
               {25'd0, p1, p2, l, m, h, tr, f});
  endtask

  // Expected zone {H, M, L} of a stored level with thresholds 50 / 90.
  function automatic logic [2:0] zone_hml(input int v);
    if (v >= 90) return 3'b100;
    if (v >= 50) return 3'b010;
    return 3'b001;
  endfunction

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst       = 1'b1;
    lvl_valid = 1'b1;
    water_lvl = '0;
    fault_clr = 1'b0;
    ticks(2);
    chk_out("rst_out", 0, 0, 1, 0, 0, 1, 0);
    check("rst_ind", ind, 0);

    // Boot: 4 cycles of dead time, then fill.
    rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk_out("boot_dead", 0, 0, 1, 0, 0, 1, 0);
    end
    tick();
    chk_out("boot_fill", 1, 0, 1, 0, 0, 1, 0);

    // Ramp 20..90; zone lags the indicator by one edge.
    prev = 0;
    for (int s = 20; s <= 90; s += 5) begin
      water_lvl = LVL_W'(s);
      tick();
      check("ramp_ind", ind, s);
      zz = zone_hml(prev);
      chk_out("ramp_out", 1, 0, zz[0], zz[1], zz[2], 1, 0);
      prev = s;
    end
    water_lvl = 8'd95;
    tick();
    chk_out("hi_dead", 0, 0, 0, 0, 1, 0, 0);
    for (int i = 2; i <= 4; i++) begin
      tick();
      chk_out("dead_drain", 0, 0, 0, 0, 1, 0, 0);
    end
    tick();
    chk_out("drain_on", 0, 1, 0, 0, 1, 0, 0);

    // Low sample at run_cnt=5: drain continues until run_cnt reaches 16.
    ticks(4);
    water_lvl = 8'd15;
    tick();
    chk_out("drain_rc5", 0, 1, 0, 0, 1, 0, 0);
    for (int k = 6; k <= 16; k++) begin
      tick();
      chk_out("drain_minrun", 0, 1, 1, 0, 0, 0, 0);
    end
    tick();
    chk_out("drain_exit", 0, 0, 1, 0, 0, 1, 0);
    ticks(3);
    chk_out("dead_fill", 0, 0, 1, 0, 0, 1, 0);
    tick();
    chk_out("refill", 1, 0, 1, 0, 0, 1, 0);

    // Back to drain, then an empty sample bypasses the minimum run.
    water_lvl = 8'd95;
    tick();
    chk_out("fill_95", 1, 0, 1, 0, 0, 1, 0);
    tick();
    chk_out("hi_dead2", 0, 0, 0, 0, 1, 0, 0);
    ticks(3);
    tick();
    chk_out("drain2_on", 0, 1, 0, 0, 1, 0, 0);
    water_lvl = 8'd0;
    tick();
    chk_out("drain2_rc1", 0, 1, 0, 0, 1, 0, 0);
    tick();
    chk_out("zero_bypass", 0, 0, 1, 0, 0, 1, 0);
    ticks(3);
    tick();
    chk_out("refill2", 1, 0, 1, 0, 0, 1, 0);

    // fault_clr outside FAULT is ignored.
    fault_clr = 1'b1;
    water_lvl = 8'd40;
    tick();
    chk_out("clr_ignored", 1, 0, 1, 0, 0, 1, 0);
    fault_clr = 1'b0;

    // Implausible sample.
    water_lvl = 8'd120;
    tick();
    chk_out("bad_fault", 0, 0, 1, 0, 0, 1, 1);
    check("bad_ind", ind, 40);
    water_lvl = 8'd40;
    tick();
    chk_out("fault_hold", 0, 0, 1, 0, 0, 1, 1);
    fault_clr = 1'b1;
    tick();
    chk_out("fault_exit", 0, 0, 1, 0, 0, 1, 0);
    fault_clr = 1'b0;
    ticks(3);
    tick();
    chk_out("fault_refill", 1, 0, 1, 0, 0, 1, 0);

    // Watchdog expiry after 1024 sample-free cycles.
    lvl_valid = 1'b0;
    ticks(1023);
    chk_out("wdog_pre", 1, 0, 1, 0, 0, 1, 0);
    tick();
    chk_out("wdog_fault", 0, 0, 1, 0, 0, 1, 1);
    fault_clr = 1'b1;
    tick();
    chk_out("wdog_clr_blocked", 0, 0, 1, 0, 0, 1, 1);
    lvl_valid = 1'b1;
    tick();
    chk_out("wdog_clr", 0, 0, 1, 0, 0, 1, 0);
    fault_clr = 1'b0;
    ticks(3);
    tick();
    chk_out("wdog_refill", 1, 0, 1, 0, 0, 1, 0);

    // A sample in the expiry cycle wins.
    lvl_valid = 1'b0;
    ticks(1023);
    lvl_valid = 1'b1;
    tick();
    chk_out("wdog_kick_win", 1, 0, 1, 0, 0, 1, 0);
    tick();
    chk_out("wdog_after_kick", 1, 0, 1, 0, 0, 1, 0);

    // Reset during DEAD_TO_DRAIN.
    water_lvl = 8'd95;
    tick();
    tick();
    chk_out("pre_rst_dead", 0, 0, 0, 0, 1, 0, 0);
    tick();
    rst       = 1'b1;
    water_lvl = 8'd0;
    tick();
    chk_out("mid_rst", 0, 0, 1, 0, 0, 1, 0);
    check("mid_rst_ind", ind, 0);
    rst = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check("no_drain_pulse", pump2, 0);
      check("post_rst_p1", pump1, (i >= 4));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
